// File: rtl/decode_bundle_unit.sv
// decode_bundle_unit
//   Registered N-wide RV32I decode stage between the fetch queue and
//   rename/dispatch. Bundles are captured into a two-entry skid buffer
//   (main M, skid S); lanes of M are decoded into a control word,
//   register indices and a sign-extended immediate. in_ready is a
//   flop (!S_valid), so there is no combinational path from out_ready
//   to in_ready.
//
//   Optional feature: define DECODE_ILLEGAL_EN to flag unknown opcodes
//   (including instr[1:0] != 2'b11) on valid lanes in ctrl bit 12.
//   Without it, bit 12 is tied to 0 and unknown opcodes decode as NOP.
//
// Ports
//   clk, rst_n         clock, async active-low reset
//   flush              drop everything buffered (dominates in_valid)
//   in_valid/in_ready  input bundle handshake
//   in_lane_valid      per-lane valid mask
//   in_instr           lane i at [32i+31:32i]
//   in_pc              PC of lane 0
//   out_valid/out_ready output bundle handshake
//   out_lane_valid     registered lane mask
//   out_ctrl           per-lane 13-bit control word
//   out_rs1/rs2/rd     per-lane register indices (0 when unused)
//   out_imm            per-lane sign-extended immediate
//   out_pc             PC of lane 0
//
// Control word: [0] branch [1] jal [2] jalr [3] alu_src1(PC) [4] alu_src2(imm)
//   [6:5] alu_op [7] rs1_used [8] rs2_used [9] load [10] store
//   [11] reg_write [12] illegal
module decode_bundle_unit #(
  parameter int WIDTH = 2,
  parameter int XLEN  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_lane_valid,
  input  logic [WIDTH*32-1:0]   in_instr,
  input  logic [XLEN-1:0]       in_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_lane_valid,
  output logic [WIDTH*13-1:0]   out_ctrl,
  output logic [WIDTH*5-1:0]    out_rs1,
  output logic [WIDTH*5-1:0]    out_rs2,
  output logic [WIDTH*5-1:0]    out_rd,
  output logic [WIDTH*XLEN-1:0] out_imm,
  output logic [XLEN-1:0]       out_pc
);

  typedef struct packed {
    logic [12:0]     ctrl;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
  } dec_t;

  function automatic dec_t decode_lane(input logic v, input logic [31:0] ins);
    dec_t        d;
    logic [31:0] imm32;
    logic        u1, u2, ud, unknown;
    logic        unused_funct3;
    d       = '0;
    imm32   = '0;
    u1      = 1'b0;
    u2      = 1'b0;
    ud      = 1'b0;
    unknown = 1'b0;
    unused_funct3 = ^ins[14:12];
    case (ins[6:0])
      7'b0110011: begin
        d.ctrl[6:5] = 2'b10; d.ctrl[7] = 1'b1; d.ctrl[8] = 1'b1; d.ctrl[11] = 1'b1;
        u1 = 1'b1; u2 = 1'b1; ud = 1'b1;
      end
      7'b0010011, 7'b0000011: begin
        d.ctrl[6:5] = 2'b11; d.ctrl[4] = 1'b1; d.ctrl[7] = 1'b1; d.ctrl[11] = 1'b1;
        d.ctrl[9] = (ins[6:0] == 7'b0000011);
        u1 = 1'b1; ud = 1'b1;
        imm32 = {{20{ins[31]}}, ins[31:20]};
      end
      7'b0100011: begin
        d.ctrl[6:5] = 2'b11; d.ctrl[4] = 1'b1; d.ctrl[7] = 1'b1; d.ctrl[8] = 1'b1;
        d.ctrl[10] = 1'b1;
        u1 = 1'b1; u2 = 1'b1;
        imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      end
      7'b1100011: begin
        d.ctrl[0] = 1'b1; d.ctrl[6:5] = 2'b01; d.ctrl[7] = 1'b1; d.ctrl[8] = 1'b1;
        u1 = 1'b1; u2 = 1'b1;
        imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      7'b1101111: begin
        d.ctrl[1] = 1'b1; d.ctrl[3] = 1'b1; d.ctrl[6:5] = 2'b11; d.ctrl[11] = 1'b1;
        ud = 1'b1;
        imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      7'b1100111: begin
        d.ctrl[2] = 1'b1; d.ctrl[4] = 1'b1; d.ctrl[6:5] = 2'b11; d.ctrl[7] = 1'b1;
        d.ctrl[11] = 1'b1;
        u1 = 1'b1; ud = 1'b1;
        imm32 = {{20{ins[31]}}, ins[31:20]};
      end
      7'b0110111, 7'b0010111: begin
        // LUI and AUIPC differ only in whether the PC is the first operand
        d.ctrl[3] = (ins[6:0] == 7'b0010111);
        d.ctrl[4] = 1'b1; d.ctrl[6:5] = 2'b11; d.ctrl[11] = 1'b1;
        ud = 1'b1;
        imm32 = {ins[31:12], 12'h000};
      end
      default: unknown = 1'b1;
    endcase
    if (ins[11:7] == 5'd0) d.ctrl[11] = 1'b0;
    d.rs1 = u1 ? ins[19:15] : 5'd0;
    d.rs2 = u2 ? ins[24:20] : 5'd0;
    d.rd  = ud ? ins[11:7]  : 5'd0;
    d.imm = XLEN'($signed(imm32));
`ifdef DECODE_ILLEGAL_EN
    d.ctrl[12] = unknown;
`else
    d.ctrl[12] = 1'b0 & unknown;
`endif
    if (!v) d = '0;
    return d;
  endfunction

  logic                m_valid, s_valid;
  logic [WIDTH-1:0]    m_lv, s_lv;
  logic [WIDTH*32-1:0] m_instr, s_instr;
  logic [XLEN-1:0]     m_pc, s_pc;
  logic                accept, m_free;

  assign in_ready = !s_valid;
  assign accept   = in_valid && in_ready;
  // M can take new data if it is empty or being drained this cycle
  assign m_free   = !m_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_lv    <= '0;
      s_lv    <= '0;
      m_instr <= '0;
      s_instr <= '0;
      m_pc    <= '0;
      s_pc    <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (m_free) begin
      if (s_valid) begin
        // S full implies in_ready=0, so nothing is accepted this cycle
        m_valid <= 1'b1;
        m_lv    <= s_lv;
        m_instr <= s_instr;
        m_pc    <= s_pc;
        s_valid <= 1'b0;
      end else begin
        m_valid <= accept;
        if (accept) begin
          m_lv    <= in_lane_valid;
          m_instr <= in_instr;
          m_pc    <= in_pc;
        end
      end
    end else if (accept) begin
      s_valid <= 1'b1;
      s_lv    <= in_lane_valid;
      s_instr <= in_instr;
      s_pc    <= in_pc;
    end
  end

  assign out_valid      = m_valid;
  assign out_lane_valid = m_lv;
  assign out_pc         = m_pc;

  for (genvar l = 0; l < WIDTH; l++) begin : g_lane
    dec_t d;
    assign d = decode_lane(m_lv[l], m_instr[32*l +: 32]);
    assign out_ctrl[13*l +: 13]     = d.ctrl;
    assign out_rs1[5*l +: 5]        = d.rs1;
    assign out_rs2[5*l +: 5]        = d.rs2;
    assign out_rd[5*l +: 5]         = d.rd;
    assign out_imm[XLEN*l +: XLEN]  = d.imm;
  end

endmodule

// File: tb/tb_decode_bundle_unit.sv
module tb_decode_bundle_unit;

  localparam int WIDTH = 2;
  localparam int XLEN  = 32;

`ifdef DECODE_ILLEGAL_EN
  localparam logic [12:0] ILL = 13'h1000;
`else
  localparam logic [12:0] ILL = 13'h0000;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      in_lane_valid;
  logic [WIDTH*32-1:0]   in_instr;
  logic [XLEN-1:0]       in_pc;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_lane_valid;
  logic [WIDTH*13-1:0]   out_ctrl;
  logic [WIDTH*5-1:0]    out_rs1;
  logic [WIDTH*5-1:0]    out_rs2;
  logic [WIDTH*5-1:0]    out_rd;
  logic [WIDTH*XLEN-1:0] out_imm;
  logic [XLEN-1:0]       out_pc;

  decode_bundle_unit #(.WIDTH(WIDTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_lane_valid(in_lane_valid), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_lane_valid(out_lane_valid), .out_ctrl(out_ctrl),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_imm(out_imm), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  lv;
    logic [31:0] i0, i1;
    logic [12:0] c0, c1;
    logic [4:0]  a0, b0, d0, a1, b1, d1;
    logic [31:0] m0, m1;
  } vec_t;

  vec_t vecs[9];

  task automatic drive(input logic [1:0] lv, input logic [31:0] i0, input logic [31:0] i1,
                       input logic [31:0] pc);
    in_valid      = 1'b1;
    in_lane_valid = lv;
    in_instr      = {i1, i0};
    in_pc         = pc;
  endtask

  task automatic check_lane0(input string nm, input logic [12:0] c, input logic [31:0] m);
    check({nm, ".ctrl0"}, 32'(out_ctrl[12:0]), 32'(c));
    check({nm, ".imm0"}, out_imm[31:0], m);
  endtask

  initial begin
    vecs[0] = '{2'b11, 32'h00500093, 32'h002081B3, 13'h8F0, 13'h9C0,
                5'd0, 5'd0, 5'd1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd0};
    vecs[1] = '{2'b11, 32'h00112423, 32'h000080E7, 13'h5F0, 13'h8F4,
                5'd2, 5'd1, 5'd0, 5'd1, 5'd0, 5'd1, 32'd8, 32'd0};
    vecs[2] = '{2'b01, 32'h123450B7, 32'hFFFFFFFF, 13'h870, 13'h000,
                5'd0, 5'd0, 5'd1, 5'd0, 5'd0, 5'd0, 32'h12345000, 32'd0};
    vecs[3] = '{2'b11, 32'h00000013, 32'h00208463, 13'h0F0, 13'h1A1,
                5'd0, 5'd0, 5'd0, 5'd1, 5'd2, 5'd0, 32'd0, 32'd8};
    vecs[4] = '{2'b11, 32'hFF9FF0EF, 32'hFFFFF297, 13'h86A, 13'h878,
                5'd0, 5'd0, 5'd1, 5'd0, 5'd0, 5'd5, 32'hFFFFFFF8, 32'hFFFFF000};
    vecs[5] = '{2'b11, 32'hFFC1A203, 32'hFE532A23, 13'hAF0, 13'h5F0,
                5'd3, 5'd0, 5'd4, 5'd6, 5'd5, 5'd0, 32'hFFFFFFFC, 32'hFFFFFFF4};
    vecs[6] = '{2'b11, 32'h0000007F, 32'h00000001, ILL, ILL,
                5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0};
    vecs[7] = '{2'b10, 32'h0000007F, 32'h0000007F, 13'h000, ILL,
                5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0};
    vecs[8] = '{2'b00, 32'h00500093, 32'h002081B3, 13'h000, 13'h000,
                5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_lane_valid = '0; in_instr = '0; in_pc = '0;
    #12;
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.in_ready", 32'(in_ready), 32'd1);
    check("rst.ctrl", 32'(out_ctrl), 32'd0);
    check("rst.imm_lo", out_imm[31:0], 32'd0);
    check("rst.pc", out_pc, 32'd0);
    check("rst.lane_valid", 32'(out_lane_valid), 32'd0);
    rst_n = 1'b1;

    // Back-to-back vectors with out_ready=1: one bundle per cycle
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].lv, vecs[i].i0, vecs[i].i1, 32'h1000 + 32'(16 * i));
      @(posedge clk); #1;
      check($sformatf("v%0d.out_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("v%0d.in_ready", i), 32'(in_ready), 32'd1);
      check($sformatf("v%0d.pc", i), out_pc, 32'h1000 + 32'(16 * i));
      check($sformatf("v%0d.lv", i), 32'(out_lane_valid), 32'(vecs[i].lv));
      check($sformatf("v%0d.ctrl0", i), 32'(out_ctrl[12:0]), 32'(vecs[i].c0));
      check($sformatf("v%0d.ctrl1", i), 32'(out_ctrl[25:13]), 32'(vecs[i].c1));
      check($sformatf("v%0d.rs1_0", i), 32'(out_rs1[4:0]), 32'(vecs[i].a0));
      check($sformatf("v%0d.rs2_0", i), 32'(out_rs2[4:0]), 32'(vecs[i].b0));
      check($sformatf("v%0d.rd_0", i), 32'(out_rd[4:0]), 32'(vecs[i].d0));
      check($sformatf("v%0d.rs1_1", i), 32'(out_rs1[9:5]), 32'(vecs[i].a1));
      check($sformatf("v%0d.rs2_1", i), 32'(out_rs2[9:5]), 32'(vecs[i].b1));
      check($sformatf("v%0d.rd_1", i), 32'(out_rd[9:5]), 32'(vecs[i].d1));
      check($sformatf("v%0d.imm0", i), out_imm[31:0], vecs[i].m0);
      check($sformatf("v%0d.imm1", i), out_imm[63:32], vecs[i].m1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("idle.out_valid", 32'(out_valid), 32'd0);

    // Backpressure: A -> M, B -> S, C refused; then drain in order
    @(negedge clk);
    out_ready = 1'b0;
    drive(2'b11, 32'h00500093, 32'h002081B3, 32'h100);
    @(posedge clk); #1;
    check("bp1.out_valid", 32'(out_valid), 32'd1);
    check("bp1.pc", out_pc, 32'h100);
    check("bp1.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    drive(2'b01, 32'h00112423, 32'h0, 32'h200);
    @(posedge clk); #1;
    check("bp2.in_ready", 32'(in_ready), 32'd0);
    check("bp2.pc", out_pc, 32'h100);
    check_lane0("bp2", 13'h8F0, 32'd5);
    @(negedge clk);
    drive(2'b01, 32'h123450B7, 32'h0, 32'h300);
    @(posedge clk); #1;
    check("bp3.in_ready", 32'(in_ready), 32'd0);
    check("bp3.pc", out_pc, 32'h100);
    check_lane0("bp3", 13'h8F0, 32'd5);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("dr1.pc", out_pc, 32'h200);
    check_lane0("dr1", 13'h5F0, 32'd8);
    check("dr1.in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check("dr2.pc", out_pc, 32'h300);
    check_lane0("dr2", 13'h870, 32'h12345000);
    check("dr2.out_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("dr3.out_valid", 32'(out_valid), 32'd0);

    // Flush with M and S full and a bundle offered the same cycle
    @(negedge clk);
    out_ready = 1'b0;
    drive(2'b01, 32'h00500093, 32'h0, 32'h400);
    @(posedge clk);
    @(negedge clk);
    drive(2'b01, 32'h00500093, 32'h0, 32'h500);
    @(posedge clk); #1;
    check("fl0.in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    flush = 1'b1;
    drive(2'b01, 32'h00500093, 32'h0, 32'h600);
    @(posedge clk); #1;
    check("fl1.out_valid", 32'(out_valid), 32'd0);
    check("fl1.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("fl%0d.no_ghost", k + 2), 32'(out_valid), 32'd0);
    end

    // Asynchronous reset between clock edges
    @(negedge clk);
    out_ready = 1'b0;
    drive(2'b01, 32'h00500093, 32'h0, 32'h700);
    @(posedge clk);
    @(negedge clk);
    drive(2'b01, 32'h00500093, 32'h0, 32'h800);
    @(posedge clk); #2;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("arst.out_valid", 32'(out_valid), 32'd0);
    check("arst.in_ready", 32'(in_ready), 32'd1);
    check("arst.pc", out_pc, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("arst.after", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_bundle_unit.md
# decode_bundle_unit

N-wide registered instruction decode stage sitting between the fetch queue and rename/dispatch in the out-of-order core. It accepts a bundle of up to `WIDTH` RV32I instructions per cycle through a valid/ready handshake and decodes each lane into a control word, register indices and a sign-extended immediate. Results are held in a two-entry skid buffer so that a backpressured downstream never causes combinational ready paths back to fetch. Compared with the single-instruction decoder, it adds JALR/LUI/AUIPC, S-type immediates, `reg_write` and per-lane valid masks.

## Interface
- `WIDTH`, 2: instructions (lanes) per bundle, 1..4.
- `XLEN`, 32: datapath and immediate width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  discard all buffered bundles.
- `in_valid`  in  1  bundle present.
- `in_ready`  out  1  unit can accept a bundle.
- `in_lane_valid`  in  WIDTH  per-lane instruction valid.
- `in_instr`  in  WIDTH*32  lane i at bits [32i+31:32i].
- `in_pc`  in  XLEN  PC of lane 0; lane i PC = in_pc + 4i.
- `out_valid`  out  1  decoded bundle present.
- `out_ready`  in  1  downstream accepts.
- `out_lane_valid`  out  WIDTH  registered copy of lane mask.
- `out_ctrl`  out  WIDTH*13  per-lane control word (layout below).
- `out_rs1`, `out_rs2`, `out_rd`  out  WIDTH*5 each  register indices.
- `out_imm`  out  WIDTH*XLEN  sign-extended immediate.
- `out_pc`  out  XLEN  PC of lane 0.

## Operation
- Control word bits: [0] branch, [1] jal, [2] jalr, [3] alu_src1 (1=PC), [4] alu_src2 (1=imm), [6:5] alu_op, [7] rs1_used, [8] rs2_used, [9] load, [10] store, [11] reg_write, [12] illegal.
- 0110011 R: alu_op=10, rs1/rs2_used, reg_write; imm=0.
- 0010011 I-ALU: alu_op=11, alu_src2, rs1_used, reg_write; I-imm.
- 0000011 LOAD: alu_op=11, alu_src2, rs1_used, load, reg_write; I-imm.
- 0100011 STORE: alu_op=11, alu_src2, rs1/rs2_used, store; S-imm.
- 1100011 BRANCH: branch, alu_op=01, rs1/rs2_used; B-imm.
- 1101111 JAL: jal, alu_src1, alu_op=11, reg_write; J-imm.
- 1100111 JALR: jalr, alu_src2, alu_op=11, rs1_used, reg_write; I-imm.
- 0110111 LUI: alu_src2, alu_op=11, reg_write, rs1_used=0, out_rs1 forced 0; U-imm.
- 0010111 AUIPC: alu_src1, alu_src2, alu_op=11, reg_write; U-imm.
- Any other opcode: control word all zero except illegal (see Configuration); indices and imm zero.
- reg_write cleared when rd=0. Unused rs1/rs2/rd indices output as 0.
- Lane with in_lane_valid=0: ctrl, indices, imm all zero; not illegal.
- Buffer: main register M and skid register S. Accept when in_valid&&in_ready. Output from M. If M occupied and not drained, accepted bundle goes to S; on drain, S moves to M.

## Timing
- Reset: out_valid=0, in_ready=1, all out_* data zero, S and M empty.
- Latency: bundle accepted in cycle t appears on outputs in t+1.
- in_ready is registered: in_ready = !S_valid. Never combinationally depends on out_ready.
- Sustained throughput one bundle/cycle with out_ready=1.
- out_* stable while out_valid && !out_ready.
- flush: M and S emptied on that edge; out_valid=0 and in_ready=1 next cycle; a same-cycle in_valid is dropped (flush dominates).
- Reset asserted mid-operation clears all state immediately, independent of clk.

## Configuration
- `DECODE_ILLEGAL_EN` defined: unknown opcodes on valid lanes, and instr[1:0]!=2'b11, set ctrl bit 12.
- Undefined: bit 12 tied 0; unknown opcodes decode silently as NOP.

## Test plan
- Reset, then WIDTH=2 bundle {0x00500093 addi x1,x0,5; 0x002081B3 add x3,x1,x2}, out_ready=1 -> next cycle lane0 ctrl alu_src2/rs1_used/reg_write, imm=5, rd=1; lane1 alu_op=10, rs1=1, rs2=2, rd=3.
- STORE 0x00112423 (sw x1,8(x2)) and JALR 0x000080E7 -> store imm=8, alu_src2=1, reg_write=0; jalr bit set, rd=1, imm=0.
- out_ready=0 for 3 cycles while 3 bundles offered -> first two captured (M,S), in_ready low cycle after second, outputs stable; release -> bundles drain in order, none lost/duplicated.
- flush with M and S full and in_valid=1 -> next cycle out_valid=0, in_ready=1; dropped bundle never appears.
- Lane mask 2'b01 with lane1 = 0xFFFFFFFF -> lane1 all zero; lane with opcode 0x7F and mask=1 -> illegal=1 only with `DECODE_ILLEGAL_EN`.
- LUI 0x123450B7 with rs1 field nonzero bits -> imm=0x12345000, out_rs1=0, rs1_used=0; addi rd=x0 -> reg_write=0.
